// File: rtl/sadd_rr_arbiter.sv
// sadd_rr_arbiter
//   Shares one signed adder among NUM_REQ requesters. Arbitration is
//   round-robin, and both sides use valid/ready handshakes. The sum is held
//   in a one-entry registered output buffer and tagged with the index of the
//   requester that won.
//
// Optional feature macro: SADD_RR_ARBITER_SAT_EN
//   Defined   : the sum saturates on signed overflow, and res_ovf is added.
//   Undefined : the sum wraps modulo 2^DATAWIDTH, and there is no res_ovf.
//
// Ports
//   Clk        rising-edge clock
//   Rst        synchronous reset, active-high
//   req_valid  per-requester request pending
//   req_ready  per-requester grant (one-hot or zero)
//   req_a      packed operand A, requester i at [i*DATAWIDTH +: DATAWIDTH]
//   req_b      packed operand B, same packing
//   res_valid  result buffer holds a valid sum
//   res_ready  consumer accepts the result
//   res_sum    signed sum
//   res_id     index of the requester that produced res_sum
//   res_ovf    (SAT_EN only) saturation occurred for res_sum
module sadd_rr_arbiter #(
  parameter int DATAWIDTH = 8,
  parameter int NUM_REQ   = 4,
  localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_b,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [DATAWIDTH-1:0]           res_sum,
`ifdef SADD_RR_ARBITER_SAT_EN
  output logic                           res_ovf,
`endif
  output logic [IDW-1:0]                 res_id
);

  logic                 res_valid_q;
  logic [DATAWIDTH-1:0] res_sum_q, res_sum_d;
  logic [IDW-1:0]       res_id_q;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic                 can_accept;
  logic                 gnt_vld;
  logic [IDW-1:0]       gnt_idx;
  logic [DATAWIDTH-1:0] op_a, op_b, raw_sum;
  logic                 xfer;
  logic                 ovf;

  // A full buffer can be refilled only in a cycle where it is also drained.
  assign can_accept = !res_valid_q | res_ready;

  // The search starts at ptr and wraps around. The wrap uses an explicit
  // compare against NUM_REQ, so NUM_REQ does not need to be a power of two.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_vld && req_valid[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(j);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_vld && can_accept && !Rst) req_ready[gnt_idx] = 1'b1;
  end

  assign xfer = |(req_valid & req_ready);

  assign op_a    = req_a[gnt_idx*DATAWIDTH +: DATAWIDTH];
  assign op_b    = req_b[gnt_idx*DATAWIDTH +: DATAWIDTH];
  assign raw_sum = op_a + op_b;
  // Overflow: both operands have the same sign and the result sign differs.
  assign ovf     = (op_a[DATAWIDTH-1] == op_b[DATAWIDTH-1]) &&
                   (raw_sum[DATAWIDTH-1] != op_a[DATAWIDTH-1]);

  always_comb begin
    res_sum_d = raw_sum;
`ifdef SADD_RR_ARBITER_SAT_EN
    if (ovf) begin
      // A negative operand sign means negative overflow, so use the minimum.
      res_sum_d = op_a[DATAWIDTH-1] ? {1'b1, {(DATAWIDTH-1){1'b0}}}
                                    : {1'b0, {(DATAWIDTH-1){1'b1}}};
    end
`endif
  end

  assign ptr_d = (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

`ifdef SADD_RR_ARBITER_SAT_EN
  logic res_ovf_q;
  always_ff @(posedge Clk) begin
    if (Rst)       res_ovf_q <= 1'b0;
    else if (xfer) res_ovf_q <= ovf;
  end
  assign res_ovf = res_ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_id_q    <= '0;
      ptr_q       <= '0;
    end else if (xfer) begin
      res_valid_q <= 1'b1;
      res_sum_q   <= res_sum_d;
      res_id_q    <= gnt_idx;
      ptr_q       <= ptr_d;
    end else if (res_ready) begin
      // Drain without a refill. The sum and id keep their last values.
      res_valid_q <= 1'b0;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_id    = res_id_q;

endmodule
